// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD limits for the countdown timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int BCD_W = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX = 9;
  localparam int ALARM_SECS = 3;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one loadable BCD down-counting digit that wraps 0->MAX and flags a borrow
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_W'(DIGIT_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] val,
  output logic             borrow
);
  logic [BCD_W-1:0] val_q, val_d;
  // load clamps out-of-range values to MAX; decrement wraps 0 to MAX
  always_comb
    val_d = load ? ((load_val > MAX) ? MAX : load_val)
          : dec_en ? ((val_q == '0) ? MAX : val_q - 1'b1) : val_q;
  // digit register
  always_ff @(posedge clk)
    if (rst) val_q <= '0;
    else val_q <= val_d;
  assign val = val_q;
  assign borrow = dec_en && (val_q == '0);
endmodule

// File: rtl/tick_countdown_timer.sv
// tick_countdown_timer: BCD mm:ss countdown paced by tick_in; optional alarm via TIMER_ALARM_EN
module tick_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             load,
  input  logic [BCD_W-1:0] min_t,
  input  logic [BCD_W-1:0] min_o,
  input  logic [BCD_W-1:0] sec_t,
  input  logic [BCD_W-1:0] sec_o,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [BCD_W-1:0] cur_min_t,
  output logic [BCD_W-1:0] cur_min_o,
  output logic [BCD_W-1:0] cur_sec_t,
  output logic [BCD_W-1:0] cur_sec_o,
  output logic             running,
  output logic             done
`ifdef TIMER_ALARM_EN
  ,
  output logic             alarm
`endif
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic done_q, done_d, running_q;
  logic dig_load, dec, time_zero, time_one, can_load, do_start, do_pause, sec_tick, alarm_run;
  logic b_so, b_st, b_mo, unused_borrow;
  assign time_zero = {cur_min_t, cur_min_o, cur_sec_t, cur_sec_o} == 16'h0000;
  assign time_one = {cur_min_t, cur_min_o, cur_sec_t, cur_sec_o} == 16'h0001;
  assign can_load = load && (state_q != RUN);
  assign do_start = start && (state_q == IDLE || state_q == PAUSE);
  assign do_pause = pause && (state_q == RUN);
  assign sec_tick = tick_in && (pre_q == PRE_MAX);
  assign dig_load = clear || can_load;
  // next state, prescaler and done pulse; earlier branches win over later ones
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    done_d = 1'b0;
    dec = 1'b0;
    if (clear) begin
      state_d = IDLE;
      pre_d = '0;
    end else if (can_load) begin
      state_d = (state_q == DONE) ? IDLE : state_q;
      pre_d = '0;
    end else if (do_start) begin
      state_d = time_zero ? DONE : RUN;
      done_d = time_zero;
      pre_d = time_zero ? '0 : pre_q;
    end else if (do_pause) begin
      state_d = PAUSE;
    end else if (tick_in && (state_q == RUN || alarm_run)) begin
      pre_d = sec_tick ? '0 : pre_q + 1'b1;
      dec = sec_tick && (state_q == RUN);
      state_d = (dec && time_one) ? DONE : state_q;
      done_d = dec && time_one;
    end
  end
  // control registers; running follows the next state so it drops as done rises
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pre_q <= '0;
      done_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      done_q <= done_d;
      running_q <= (state_d == RUN);
    end
  assign running = running_q;
  assign done = done_q;
  bcd_digit_down #(.MAX(BCD_W'(DIGIT_MAX))) u_sec_o (
    .clk(clk), .rst(rst), .dec_en(dec), .load(dig_load),
    .load_val(clear ? '0 : sec_o), .val(cur_sec_o), .borrow(b_so)
  );
  bcd_digit_down #(.MAX(BCD_W'(SEC_TENS_MAX))) u_sec_t (
    .clk(clk), .rst(rst), .dec_en(b_so), .load(dig_load),
    .load_val(clear ? '0 : sec_t), .val(cur_sec_t), .borrow(b_st)
  );
  bcd_digit_down #(.MAX(BCD_W'(DIGIT_MAX))) u_min_o (
    .clk(clk), .rst(rst), .dec_en(b_st), .load(dig_load),
    .load_val(clear ? '0 : min_o), .val(cur_min_o), .borrow(b_mo)
  );
  bcd_digit_down #(.MAX(BCD_W'(DIGIT_MAX))) u_min_t (
    .clk(clk), .rst(rst), .dec_en(b_mo), .load(dig_load),
    .load_val(clear ? '0 : min_t), .val(cur_min_t), .borrow(unused_borrow)
  );
`ifdef TIMER_ALARM_EN
  logic alarm_q, alarm_d;
  logic [1:0] asec_q, asec_d;
  assign alarm_run = alarm_q && (state_q == DONE);
  // alarm raised with done, held for ALARM_SECS prescaler seconds, dropped by clear or load
  always_comb begin
    alarm_d = alarm_q;
    asec_d = asec_q;
    if (clear || can_load) begin
      alarm_d = 1'b0;
      asec_d = '0;
    end else if (done_d) begin
      alarm_d = 1'b1;
      asec_d = '0;
    end else if (alarm_run && sec_tick) begin
      asec_d = asec_q + 1'b1;
      alarm_d = asec_q != 2'(ALARM_SECS - 1);
    end
  end
  // alarm registers
  always_ff @(posedge clk)
    if (rst) begin
      alarm_q <= 1'b0;
      asec_q <= '0;
    end else begin
      alarm_q <= alarm_d;
      asec_q <= asec_d;
    end
  assign alarm = alarm_q;
`else
  assign alarm_run = 1'b0;
`endif
endmodule

// File: tb/tb_tick_countdown_timer.sv
// tb_tick_countdown_timer: directed and randomized checks against a seconds-based model
module tb_tick_countdown_timer;
  localparam int T = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  logic clk = 0, rst = 1, tick_in = 0, load = 0, start = 0, pause = 0, clear = 0;
  logic [3:0] min_t = 0, min_o = 0, sec_t = 0, sec_o = 0;
  logic [3:0] cur_min_t, cur_min_o, cur_sec_t, cur_sec_o;
  logic running, done;
  wire [15:0] cur_all = {cur_min_t, cur_min_o, cur_sec_t, cur_sec_o};
  int n_chk = 0, n_fail = 0;
  int m_secs = 0, m_pre = 0, m_st = S_IDLE;
  bit m_run = 0, m_done = 0, chk = 0;

  tick_countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .load(load),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .start(start), .pause(pause), .clear(clear),
    .cur_min_t(cur_min_t), .cur_min_o(cur_min_o), .cur_sec_t(cur_sec_t), .cur_sec_o(cur_sec_o),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int s);
    int m = s / 60, ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int lim(input logic [3:0] v, input int mx);
    return (int'(v) > mx) ? mx : int'(v);
  endfunction

  task automatic chk_one(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
    chk_one(name, act, exp);
    chk_one({name, " model"}, mdl, exp);
  endtask

  // time kept as total seconds; digits derived by division
  task automatic model_step();
    m_done = 0;
    if (rst) begin
      m_secs = 0; m_pre = 0; m_st = S_IDLE;
    end else if (clear) begin
      m_secs = 0; m_pre = 0; m_st = S_IDLE;
    end else if (load && m_st != S_RUN) begin
      m_secs = (lim(min_t, 9) * 10 + lim(min_o, 9)) * 60 + lim(sec_t, 5) * 10 + lim(sec_o, 9);
      m_pre = 0;
      if (m_st == S_DONE) m_st = S_IDLE;
    end else if (start && (m_st == S_IDLE || m_st == S_PAUSE)) begin
      if (m_secs == 0) begin m_st = S_DONE; m_done = 1; end
      else m_st = S_RUN;
    end else if (pause && m_st == S_RUN) begin
      m_st = S_PAUSE;
    end else if (tick_in && m_st == S_RUN) begin
      m_pre++;
      if (m_pre == T) begin
        m_pre = 0;
        m_secs--;
        if (m_secs == 0) begin m_st = S_DONE; m_done = 1; end
      end
    end
    m_run = (m_st == S_RUN);
  endtask

  task automatic clk1();
    @(posedge clk);
    model_step();
    #1;
    tick_in = 0; load = 0; start = 0; pause = 0; clear = 0;
  endtask

  task automatic set_t(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    min_t = a; min_o = b; sec_t = c; sec_o = d;
  endtask

  always @(negedge clk)
    if (chk) begin
      chk_one("time", cur_all, bcd(m_secs));
      chk_one("running", {15'd0, running}, {15'd0, m_run});
      chk_one("done", {15'd0, done}, {15'd0, m_done});
    end

  initial begin
    rst = 1;
    clk1(); clk1();
    rst = 0;
    chk = 1;
    lit("reset time", cur_all, bcd(m_secs), 16'h0000);
    lit("reset running", {15'd0, running}, {15'd0, m_run}, 16'h0000);
    set_t(0, 0, 0, 3); load = 1; clk1();
    start = 1; clk1();
    lit("t1 run", {15'd0, running}, {15'd0, m_run}, 16'h0001);
    for (int i = 1; i <= 6; i++) begin
      tick_in = 1; clk1();
      if (i == 2) lit("t1 0002", cur_all, bcd(m_secs), 16'h0002);
      if (i == 4) lit("t1 0001", cur_all, bcd(m_secs), 16'h0001);
      if (i == 6) begin
        lit("t1 0000", cur_all, bcd(m_secs), 16'h0000);
        lit("t1 done", {15'd0, done}, {15'd0, m_done}, 16'h0001);
        lit("t1 stop", {15'd0, running}, {15'd0, m_run}, 16'h0000);
      end
      clk1();
    end
    lit("t1 done once", {15'd0, done}, {15'd0, m_done}, 16'h0000);
    set_t(0, 1, 0, 0); load = 1; clk1();
    start = 1; clk1();
    for (int i = 0; i < 22; i++) begin
      tick_in = 1; clk1();
      if (i == 1) lit("t2 0059", cur_all, bcd(m_secs), 16'h0059);
      clk1();
    end
    lit("t2 0049", cur_all, bcd(m_secs), 16'h0049);
    clear = 1; clk1();
    set_t(0, 0, 1, 0); load = 1; clk1();
    start = 1; clk1();
    tick_in = 1; clk1(); clk1();
    tick_in = 1; pause = 1; clk1();
    lit("t3 held", cur_all, bcd(m_secs), 16'h0010);
    lit("t3 paused", {15'd0, running}, {15'd0, m_run}, 16'h0000);
    start = 1; clk1();
    tick_in = 1; clk1();
    lit("t3 0009", cur_all, bcd(m_secs), 16'h0009);
    clear = 1; clk1();
    start = 1; clk1();
    lit("t4 done", {15'd0, done}, {15'd0, m_done}, 16'h0001);
    clk1();
    lit("t4 done once", {15'd0, done}, {15'd0, m_done}, 16'h0000);
    set_t(0, 0, 0, 5); load = 1; clk1();
    start = 1; clk1();
    set_t(1, 2, 3, 4); load = 1; clk1();
    lit("t4 load ignored", cur_all, bcd(m_secs), 16'h0005);
    clear = 1; clk1();
    set_t(4'hA, 7, 9, 4'hF); load = 1; clk1();
    lit("t5 clamp", cur_all, bcd(m_secs), 16'h9759);
    start = 1; clk1();
    tick_in = 1; clk1(); clk1(); tick_in = 1; clk1();
    lit("t5 9758", cur_all, bcd(m_secs), 16'h9758);
    clear = 1; clk1();
    lit("t5 clear", cur_all, bcd(m_secs), 16'h0000);
    lit("t5 idle", {15'd0, running}, {15'd0, m_run}, 16'h0000);
    for (int i = 0; i < 4000; i++) begin
      bit last_tick;
      last_tick = (i % 2 == 1) ? 1'b0 : 1'b1;
      tick_in = ($urandom_range(0, 2) == 0) && last_tick;
      load = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 511) == 0);
      if ($urandom_range(0, 3) != 0) set_t(0, 0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      else set_t(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      clk1();
      rst = 0;
    end
    rst = 1; clk1(); rst = 0;
    lit("final reset", cur_all, bcd(m_secs), 16'h0000);
    @(negedge clk);
    chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
